// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between the digit-code producer and the scan controller.
// The producer holds digit/load_req until it sees load_ack.
interface seg_scan_ctrl_if;
    logic [19:0] digit;
    logic        load_req;
    logic        load_ack;

    modport master (
        output digit,
        output load_req,
        input  load_ack
    );

    modport slave (
        input  digit,
        input  load_req,
        output load_ack
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: frame-coherent shadow digits,
// round-robin mux select, per-slot dead-time, active-low anodes, zero blanking.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | display dark, slot/cyc held at 0, loads captured on any edge
//   S_SCAN | refreshing digits, loads captured only at the frame boundary
module seg_scan_ctrl #(
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 zero_suppress_i,
    seg_scan_ctrl_if.slave       ld,
    output logic [4:0]           dig0_o,
    output logic [4:0]           dig1_o,
    output logic [4:0]           dig2_o,
    output logic [4:0]           dig3_o,
    output logic [1:0]           control_o,
    output logic [3:0]           anode_o,
    output logic                 blank_o
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CYC_LAST = CW'(PRESCALE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [3:0][4:0] dig_q, dig_d;
    logic [3:0]      anode_q, anode_d;
    logic            blank_q, blank_d;
    logic [1:0]      control_q, control_d;
    logic            ack_q, ack_d;
    logic            capture;
    logic            in_blank;
    logic [3:0]      sup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            slot_q    <= 2'd0;
            cyc_q     <= '0;
            dig_q     <= '0;
            anode_q   <= 4'hF;
            blank_q   <= 1'b1;
            control_q <= 2'd0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cyc_q     <= cyc_d;
            dig_q     <= dig_d;
            anode_q   <= anode_d;
            blank_q   <= blank_d;
            control_q <= control_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        cyc_d     = cyc_q;
        dig_d     = dig_q;
        ack_d     = 1'b0;
        capture   = 1'b0;
        anode_d   = 4'hF;
        blank_d   = 1'b1;
        control_d = 2'd0;
        in_blank  = 1'b1;
        sup       = 4'b0000;

        unique case (state_q)
            S_IDLE: begin
                slot_d = 2'd0;
                cyc_d  = '0;
                // Skipping the edge after an ACK keeps one ACK per request.
                capture = ld.load_req && !ack_q;
                if (enable_i) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                    slot_d  = 2'd0;
                    cyc_d   = '0;
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    slot_d  = slot_q + 2'd1;
                    capture = ld.load_req && (slot_q == 2'd3);
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            dig_d = ld.digit;
            ack_d = 1'b1;
        end

        // A slot is dark when it and every more significant digit are zero.
        sup[3] = zero_suppress_i && (dig_d[3] == 5'd0);
        sup[2] = sup[3] && (dig_d[2] == 5'd0);
        sup[1] = sup[2] && (dig_d[1] == 5'd0);
        sup[0] = 1'b0;

        in_blank = int'(cyc_d) < BLANK_CYC;

        if (state_d == S_SCAN) begin
            control_d = slot_d;
            if (!in_blank && !sup[slot_d]) begin
                anode_d = ~(4'b0001 << slot_d);
                blank_d = 1'b0;
            end
        end
    end

    assign ld.load_ack = ack_q;
    assign dig0_o      = dig_q[0];
    assign dig1_o      = dig_q[1];
    assign dig2_o      = dig_q[2];
    assign dig3_o      = dig_q[3];
    assign control_o   = control_q;
    assign anode_o     = anode_q;
    assign blank_o     = blank_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=8, BLANK_CYC=2, plus a
// BLANK_CYC=0 instance running in lockstep for the no-dead-time case.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       zero_suppress;
    logic [4:0] dig0, dig1, dig2, dig3;
    logic [1:0] control;
    logic [3:0] anode;
    logic       blank;
    logic [4:0] z_dig0, z_dig1, z_dig2, z_dig3;
    logic [1:0] z_control;
    logic [3:0] z_anode;
    logic       z_blank;

    int n_checks;
    int n_fail;

    seg_scan_ctrl_if ifc ();
    seg_scan_ctrl_if if0 ();

    assign if0.digit    = ifc.digit;
    assign if0.load_req = ifc.load_req;

    seg_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(2)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .zero_suppress_i (zero_suppress),
        .ld              (ifc),
        .dig0_o          (dig0),
        .dig1_o          (dig1),
        .dig2_o          (dig2),
        .dig3_o          (dig3),
        .control_o       (control),
        .anode_o         (anode),
        .blank_o         (blank)
    );

    seg_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(0)) u_dut_nb (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .zero_suppress_i (zero_suppress),
        .ld              (if0),
        .dig0_o          (z_dig0),
        .dig1_o          (z_dig1),
        .dig2_o          (z_dig2),
        .dig3_o          (z_dig3),
        .control_o       (z_control),
        .anode_o         (z_anode),
        .blank_o         (z_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) tick();
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1 || control !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got an=%h bl=%b ctl=%0d exp an=f bl=1 ctl=0", anode, blank, control);
        end
        n_checks++;
        if ({dig3, dig2, dig1, dig0} !== 20'h0 || ifc.load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_digits got dig=%h ack=%b exp dig=0 ack=0", {dig3, dig2, dig1, dig0}, ifc.load_ack);
        end
        n_checks++;
        if (z_anode !== 4'hF || z_blank !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_nb_outputs got an=%h bl=%b exp an=f bl=1", z_anode, z_blank);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1 || control !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_hold got an=%h bl=%b ctl=%0d exp an=f bl=1 ctl=0", anode, blank, control);
        end
    endtask

    task automatic test_load_idle();
        ifc.digit    = 20'h20C41;
        ifc.load_req = 1'b1;
        tick();
        n_checks++;
        if (ifc.load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ack got %b exp 1", ifc.load_ack);
        end
        n_checks++;
        if (dig0 !== 5'h01 || dig1 !== 5'h02 || dig2 !== 5'h03 || dig3 !== 5'h04) begin
            n_fail++;
            $display("FAIL idle_capture got %h %h %h %h exp 04 03 02 01", dig3, dig2, dig1, dig0);
        end
        tick();
        n_checks++;
        if (ifc.load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_single_ack got %b exp 0", ifc.load_ack);
        end
        ifc.load_req = 1'b0;
        tick();
        n_checks++;
        if (ifc.load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_drop got %b exp 0", ifc.load_ack);
        end
    endtask

    task automatic test_scan();
        logic [3:0] one;
        logic [3:0] exp_an;
        logic       exp_bl;
        one    = 4'b0001;
        enable = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 8; c++) begin
                    exp_bl = (c < 2);
                    exp_an = exp_bl ? 4'hF : ~(one << s);
                    n_checks++;
                    if (anode !== exp_an || blank !== exp_bl || control !== 2'(s)) begin
                        n_fail++;
                        $display("FAIL scan_seq f%0d s%0d c%0d got an=%h bl=%b ctl=%0d exp an=%h bl=%b ctl=%0d",
                                 f, s, c, anode, blank, control, exp_an, exp_bl, s);
                    end
                    tick();
                end
            end
        end
    endtask

    task automatic test_load_scan();
        int waited;
        for (int i = 0; i < 8; i++) tick();
        ifc.digit    = 20'h12345;
        ifc.load_req = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
            if (waited == 23) begin
                n_checks++;
                if (dig0 !== 5'h01 || dig3 !== 5'h04 || ifc.load_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL scan_no_tear got d0=%h d3=%h ack=%b exp d0=01 d3=04 ack=0", dig0, dig3, ifc.load_ack);
                end
            end
        end while (ifc.load_ack !== 1'b1 && waited < 40);
        n_checks++;
        if (waited !== 24 || ifc.load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_ack_latency got %0d cycles ack=%b exp 24 cycles ack=1", waited, ifc.load_ack);
        end
        n_checks++;
        if (dig0 !== 5'h05 || dig1 !== 5'h1A || dig2 !== 5'h08 || dig3 !== 5'h02) begin
            n_fail++;
            $display("FAIL scan_capture got %h %h %h %h exp 02 08 1a 05", dig3, dig2, dig1, dig0);
        end
        n_checks++;
        if (control !== 2'd0 || anode !== 4'hF || blank !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_boundary got ctl=%0d an=%h bl=%b exp ctl=0 an=f bl=1", control, anode, blank);
        end
        waited = 0;
        do begin
            tick();
            waited++;
        end while (ifc.load_ack !== 1'b1 && waited < 40);
        n_checks++;
        if (waited !== 32) begin
            n_fail++;
            $display("FAIL scan_ack_period got %0d cycles exp 32", waited);
        end
        ifc.load_req = 1'b0;
        tick();
        n_checks++;
        if (ifc.load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_ack_pulse got %b exp 0", ifc.load_ack);
        end
    endtask

    task automatic test_zero_suppress();
        logic [3:0]  one;
        logic [3:0]  exp_an;
        logic        exp_bl;
        logic [3:0]  mask;
        logic [19:0] word;
        one = 4'b0001;
        zero_suppress = 1'b1;
        for (int p = 0; p < 2; p++) begin
            word = (p == 0) ? 20'h00000 : 20'h04000;
            mask = (p == 0) ? 4'b1110 : 4'b1000;
            enable = 1'b0;
            tick();
            ifc.digit    = word;
            ifc.load_req = 1'b1;
            tick();
            n_checks++;
            if (ifc.load_ack !== 1'b1 || {dig3, dig2, dig1, dig0} !== word) begin
                n_fail++;
                $display("FAIL zs_load p%0d got ack=%b dig=%h exp ack=1 dig=%h", p, ifc.load_ack, {dig3, dig2, dig1, dig0}, word);
            end
            ifc.load_req = 1'b0;
            enable = 1'b1;
            tick();
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 8; c++) begin
                    exp_bl = (c < 2) || mask[s];
                    exp_an = exp_bl ? 4'hF : ~(one << s);
                    n_checks++;
                    if (anode !== exp_an || blank !== exp_bl || control !== 2'(s)) begin
                        n_fail++;
                        $display("FAIL zs_frame p%0d s%0d c%0d got an=%h bl=%b ctl=%0d exp an=%h bl=%b ctl=%0d",
                                 p, s, c, anode, blank, control, exp_an, exp_bl, s);
                    end
                    tick();
                end
            end
        end
        zero_suppress = 1'b0;
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (anode !== 4'hB || blank !== 1'b0 || control !== 2'd2) begin
            n_fail++;
            $display("FAIL drop_pre got an=%h bl=%b ctl=%0d exp an=b bl=0 ctl=2", anode, blank, control);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1 || control !== 2'd0) begin
            n_fail++;
            $display("FAIL drop_idle got an=%h bl=%b ctl=%0d exp an=f bl=1 ctl=0", anode, blank, control);
        end
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b1;
        tick();
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1 || control !== 2'd0) begin
            n_fail++;
            $display("FAIL restart_c0 got an=%h bl=%b ctl=%0d exp an=f bl=1 ctl=0", anode, blank, control);
        end
        tick();
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_c1 got an=%h bl=%b exp an=f bl=1", anode, blank);
        end
        tick();
        n_checks++;
        if (anode !== 4'hE || blank !== 1'b0 || control !== 2'd0) begin
            n_fail++;
            $display("FAIL restart_c2 got an=%h bl=%b ctl=%0d exp an=e bl=0 ctl=0", anode, blank, control);
        end
    endtask

    task automatic test_no_blank();
        logic [3:0] one;
        logic [3:0] exp_an;
        one    = 4'b0001;
        enable = 1'b0;
        tick();
        n_checks++;
        if (z_anode !== 4'hF || z_blank !== 1'b1) begin
            n_fail++;
            $display("FAIL nb_idle got an=%h bl=%b exp an=f bl=1", z_anode, z_blank);
        end
        enable = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                exp_an = ~(one << s);
                n_checks++;
                if (z_anode !== exp_an || z_blank !== 1'b0 || z_control !== 2'(s)) begin
                    n_fail++;
                    $display("FAIL nb_frame s%0d c%0d got an=%h bl=%b ctl=%0d exp an=%h bl=0 ctl=%0d",
                             s, c, z_anode, z_blank, z_control, exp_an, s);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_midscan();
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (anode !== 4'hB || control !== 2'd2 || dig2 !== 5'h10) begin
            n_fail++;
            $display("FAIL midscan_pre got an=%h ctl=%0d d2=%h exp an=b ctl=2 d2=10", anode, control, dig2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1 || control !== 2'd0 || ifc.load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_reset got an=%h bl=%b ctl=%0d ack=%b exp an=f bl=1 ctl=0 ack=0",
                     anode, blank, control, ifc.load_ack);
        end
        n_checks++;
        if ({dig3, dig2, dig1, dig0} !== 20'h0) begin
            n_fail++;
            $display("FAIL midscan_digits got %h exp 00000", {dig3, dig2, dig1, dig0});
        end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (anode !== 4'hF || blank !== 1'b1 || control !== 2'd0 || {dig3, dig2, dig1, dig0} !== 20'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle got an=%h bl=%b ctl=%0d dig=%h exp an=f bl=1 ctl=0 dig=0",
                     anode, blank, control, {dig3, dig2, dig1, dig0});
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        enable        = 1'b0;
        zero_suppress = 1'b0;
        ifc.digit     = 20'h0;
        ifc.load_req  = 1'b0;

        test_reset();
        test_load_idle();
        test_scan();
        test_load_scan();
        test_zero_suppress();
        test_enable_drop();
        test_no_blank();
        test_reset_midscan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the four-digit seven-segment display path. Holds a frame-coherent shadow copy of four 5-bit digit codes, which feed the 4:1 digit multiplexer inputs. Drives the 2-bit multiplexer select in a round-robin refresh, with per-slot blanking (ghosting dead-time), active-low anode strobes and optional leading-zero suppression. Digit code format: bit 4 = decimal point, bits 3:0 = hex nibble.

## Interface
- PRESCALE, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); legal ≥ 2.
- BLANK_CYC, 1000: blank cycles at the start of each slot; legal 0 ≤ BLANK_CYC < PRESCALE.

- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  scanning enable; low = display dark, scan held at slot 0.
- ZERO_SUPPRESS  in  1  blank leading zero digits (3..1).
- DIGIT_IN  in  20  new digit codes {D3,D2,D1,D0}, 5 bits each.
- LOAD_REQ  in  1  request to capture DIGIT_IN into the shadow registers.
- LOAD_ACK  out  1  one-cycle pulse: capture done.
- DIG0..DIG3  out  5 each  shadow registers; wire to multiplexer IN0..IN3.
- CONTROL  out  2  multiplexer select = current slot.
- ANODE  out  4  active-low digit strobes; bit i = digit i.
- BLANK  out  1  high = segment decoder must drive all segments off.

## Operation
- States: IDLE (ENABLE low) and SCAN. All outputs registered.
- Counters: slot (2 bit) and cyc (0..PRESCALE-1).
- IDLE: slot=0, cyc=0, ANODE=4'hF, BLANK=1, CONTROL=0.
- IDLE→SCAN: on the edge sampling ENABLE=1.
- SCAN: cyc increments each cycle. At cyc=PRESCALE-1, cyc→0 and slot→slot+1, wrapping 3→0.
- Frame boundary: the edge where slot wraps 3→0.
- SCAN, cyc < BLANK_CYC: ANODE=4'hF, BLANK=1.
- SCAN, otherwise: BLANK=0 and ANODE=~(4'b0001<<slot), unless the slot is suppressed.
- CONTROL = slot at all times in SCAN.
- Suppression: slot i (i ∈ 1..3) is suppressed iff ZERO_SUPPRESS=1 and DIGj==5'd0 for every j ≥ i.
  - Evaluated on the shadow registers.
  - Suppressed slot: ANODE=4'hF and BLANK=1 for the whole slot.
  - Slot 0 is never suppressed.
- SCAN→IDLE: the edge sampling ENABLE=0. IDLE outputs apply from that edge; slot/cyc are cleared, so re-enable always restarts at slot 0, blank phase.
- Load handshake:
  - The requester raises LOAD_REQ and holds DIGIT_IN stable until it sees LOAD_ACK=1.
  - Capture edge (SCAN): a frame boundary with LOAD_REQ=1.
  - Capture edge (IDLE): any edge with LOAD_REQ=1.
  - On the capture edge, DIG0..3 ← DIGIT_IN and LOAD_ACK←1 for exactly one cycle.
  - The requester drops LOAD_REQ in the cycle after the ACK.
  - If LOAD_REQ is still high at the next capture opportunity, another capture occurs. No capture happens in the cycle immediately following an ACK in IDLE, so one ACK is issued per request.
  - Shadow registers never change mid-frame, so there is no tearing.
- Reset (asynchronous, RESET_N=0, any cycle):
  - State IDLE; slot=0; cyc=0.
  - DIG0..3=0; CONTROL=0; ANODE=4'hF; BLANK=1; LOAD_ACK=0.
  - A pending request is dropped; the requester re-issues it.

## Timing
- Slot length is exactly PRESCALE cycles; frame is 4·PRESCALE cycles.
- First SCAN cycle follows the ENABLE-sampling edge, with slot 0, cyc 0.
- ANODE/BLANK transitions are coincident with the slot change (same edge). CONTROL changes on that same edge, i.e. while blanked, provided BLANK_CYC ≥ 1.
- BLANK_CYC=0: no dead-time; the anode switches directly between digits.
- LOAD_ACK latency from LOAD_REQ rise:
  - IDLE: 1 edge.
  - SCAN: up to 4·PRESCALE cycles (until the next frame boundary).
- A new digit value is first displayed in slot 0 of the frame starting at the capture edge.

## Test plan
Benches use PRESCALE=8, BLANK_CYC=2.

1. Reset/idle: RESET_N=0 mid-scan (slot 2, ON phase) → same cycle ANODE=F, BLANK=1, CONTROL=0, DIG*=0, LOAD_ACK=0; hold ENABLE=0 → outputs unchanged.
2. Scan sequence: DIG={5'h04,5'h03,5'h02,5'h01}, ENABLE=1 → per slot, 2 cycles ANODE=F, then 6 cycles ANODE=E,D,B,7 for slots 0..3; CONTROL=0,1,2,3; frame period 32 cycles; wraps to slot 0.
3. Load handshake in SCAN: LOAD_REQ=1 with DIGIT_IN=20'h12345 at slot 1 → LOAD_ACK pulses once, exactly at the 3→0 edge; DIG* update on that edge; holding LOAD_REQ through 2 frames → 2 ACKs 32 cycles apart.
4. Load in IDLE: LOAD_REQ=1 → LOAD_ACK=1 on the next edge; DIG* = DIGIT_IN.
5. Zero suppression: DIG3=0, DIG2=0, DIG1=5'h00, DIG0=5'h00, ZERO_SUPPRESS=1 → slots 1–3 fully dark, slot 0 shows (ANODE=E). Then DIG2=5'h10 (DP only) → slot 3 dark, slots 2/1 lit.
6. ENABLE drop/re-raise mid-slot 2 → IDLE outputs at the sampling edge; re-enable → restart slot 0 with a full 2-cycle blank. BLANK_CYC=0 variant → ANODE never all-ones in SCAN.
